maquina_estados_mascota: RTL and testbench

//  Pet behaviour FSM that sits directly downstream of the mode/level block (Modos).

---
 rtl/maquina_estados_mascota_pkg.sv | 39 +++
 rtl/maquina_estados_mascota_contador_ciclos.sv | 29 ++
 rtl/maquina_estados_mascota.sv | 108 ++++++++++
 tb/tb_maquina_estados_mascota.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/maquina_estados_mascota_pkg.sv
// Shared definitions for the pet behaviour FSM and the display decoder:
// state codes, field widths, level thresholds and the level-priority evaluation.
package pkg_mascota;

   localparam int STATE_W = 3;
   localparam int LEVEL_W = 2;

   localparam logic [LEVEL_W-1:0] NIVEL_BAJO = 2'd1;
   localparam logic [LEVEL_W-1:0] NIVEL_CERO = 2'd0;
   localparam logic [LEVEL_W-1:0] NIVEL_DESPIERTO = 2'd2;

   typedef enum logic [STATE_W-1:0] {
      NEUTRAL = 3'd0,
      HAMBRE  = 3'd1,
      CANSADO = 3'd2,
      TRISTE  = 3'd3,
      ENFERMO = 3'd4,
      DORMIDO = 3'd5,
      MUERTO  = 3'd6
   } estado_t;

   // Highest-priority need wins; the same ordering is used on test exit and DORMIDO exit.
   function automatic estado_t evalua_niveles(
      input logic [LEVEL_W-1:0] animo,
      input logic [LEVEL_W-1:0] energia,
      input logic [LEVEL_W-1:0] descanso,
      input logic [LEVEL_W-1:0] medicina
   );
      estado_t res;
      if (medicina <= NIVEL_BAJO)       res = ENFERMO;
      else if (energia <= NIVEL_BAJO)   res = HAMBRE;
      else if (descanso == NIVEL_CERO)  res = DORMIDO;
      else if (descanso == NIVEL_BAJO)  res = CANSADO;
      else if (animo <= NIVEL_BAJO)     res = TRISTE;
      else                              res = NEUTRAL;
      return res;
   endfunction

endpackage

// File: rtl/maquina_estados_mascota_contador_ciclos.sv
// Saturating up-counter: done while the count sits at N-1; clr has priority over en.
module contador_ciclos #(
   parameter int N = 10
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic done
);

   localparam int W = (N > 1) ? $clog2(N) : 1;
   localparam logic [W-1:0] ULTIMO = W'(N - 1);

   logic [W-1:0] cuenta;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cuenta <= '0;
      end else if (clr) begin
         cuenta <= '0;
      end else if (en && (cuenta != ULTIMO)) begin
         cuenta <= cuenta + 1'b1;
      end
   end

   assign done = (cuenta == ULTIMO);

endmodule

// File: rtl/maquina_estados_mascota.sv
// Pet behaviour FSM downstream of Modos: picks the displayed state from the need
// levels, runs the death timer and the test-mode state walk, and decodes the feed enables.
//
// state   | meaning
// NEUTRAL | all needs satisfied
// HAMBRE  | energia low
// CANSADO | descanso at 1
// TRISTE  | animo low
// ENFERMO | medicina low, medicine accepted
// DORMIDO | sleeping until descanso recovers to 2+
// MUERTO  | energia or medicina at 0 for DEAD_CYCLES cycles, left only by reset
// (modo_test=1 overrides the meaning: estado just walks 0..6)
module maquina_estados_mascota
   import pkg_mascota::*;
#(
   parameter int TEST_CYCLES = 10,
   parameter int DEAD_CYCLES = 30
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               test,
   input  logic [LEVEL_W-1:0] nivel_animo,
   input  logic [LEVEL_W-1:0] nivel_energia,
   input  logic [LEVEL_W-1:0] nivel_descanso,
   input  logic [LEVEL_W-1:0] nivel_medicina,
   output logic [STATE_W-1:0] estado,
   output logic               activo_comida,
   output logic               activo_medicina,
   output logic               modo_test
);

   estado_t est_q, est_d;
   logic    test_q, test_d;

   logic cond_muerte;
   logic fin_test;
   logic fin_muerte;
   logic muerte_tc;

   assign cond_muerte = (nivel_energia == NIVEL_CERO) || (nivel_medicina == NIVEL_CERO);
   assign muerte_tc   = fin_muerte && cond_muerte && !test_q;

   contador_ciclos #(.N(TEST_CYCLES)) u_timer_test (
      .clk   (clk),
      .reset (reset),
      .clr   (!test_q || fin_test),
      .en    (test_q),
      .done  (fin_test)
   );

   // Held at zero in test mode so leaving test never inherits a stale count.
   contador_ciclos #(.N(DEAD_CYCLES)) u_timer_muerte (
      .clk   (clk),
      .reset (reset),
      .clr   (!cond_muerte || test_q),
      .en    (cond_muerte),
      .done  (fin_muerte)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         est_q  <= NEUTRAL;
         test_q <= 1'b0;
      end else begin
         est_q  <= est_d;
         test_q <= test_d;
      end
   end

   always_comb begin
      est_d  = est_q;
      test_d = test_q;
      if (test_q) begin
         // In test mode estado may legitimately read MUERTO, so this branch comes first.
         if (test) begin
            test_d = 1'b0;
            est_d  = evalua_niveles(nivel_animo, nivel_energia, nivel_descanso, nivel_medicina);
         end else if (fin_test) begin
            est_d = (est_q == MUERTO) ? NEUTRAL : estado_t'(est_q + 3'd1);
         end
      end else if (est_q == MUERTO) begin
         est_d = MUERTO;
      end else if (muerte_tc) begin
         est_d = MUERTO;
      end else if (test) begin
         test_d = 1'b1;
         est_d  = NEUTRAL;
      end else if (est_q == DORMIDO) begin
         if (nivel_medicina <= NIVEL_BAJO) begin
            est_d = ENFERMO;
         end else if (nivel_descanso >= NIVEL_DESPIERTO) begin
            est_d = evalua_niveles(nivel_animo, nivel_energia, nivel_descanso, nivel_medicina);
         end else begin
            est_d = DORMIDO;
         end
      end else begin
         est_d = evalua_niveles(nivel_animo, nivel_energia, nivel_descanso, nivel_medicina);
      end
   end

   always_comb begin
      estado          = est_q;
      modo_test       = test_q;
      activo_comida   = !(test_q || (est_q == DORMIDO) || (est_q == MUERTO));
      activo_medicina = !test_q && (est_q == ENFERMO);
   end

endmodule

// File: tb/tb_maquina_estados_mascota.sv
// Directed bench for the pet FSM: expected outputs are queued as stimulus is applied
// and popped against the DUT one time unit after each rising edge.
module tb_maquina_estados_mascota;

   logic       clk;
   logic       reset;
   logic       test;
   logic [1:0] nivel_animo, nivel_energia, nivel_descanso, nivel_medicina;
   logic [2:0] estado;
   logic       activo_comida, activo_medicina, modo_test;

   typedef struct {
      string      tag;
      logic [5:0] val;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_errors = 0;

   maquina_estados_mascota #(.TEST_CYCLES(10), .DEAD_CYCLES(30)) dut (
      .clk             (clk),
      .reset           (reset),
      .test            (test),
      .nivel_animo     (nivel_animo),
      .nivel_energia   (nivel_energia),
      .nivel_descanso  (nivel_descanso),
      .nivel_medicina  (nivel_medicina),
      .estado          (estado),
      .activo_comida   (activo_comida),
      .activo_medicina (activo_medicina),
      .modo_test       (modo_test)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic set_lv(input int a, input int e, input int d, input int m);
      nivel_animo    = 2'(a);
      nivel_energia  = 2'(e);
      nivel_descanso = 2'(d);
      nivel_medicina = 2'(m);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input string tag, input int est, input int com, input int med, input int tst);
      exp_t x;
      x.tag = tag;
      x.val = {3'(est), 1'(com), 1'(med), 1'(tst)};
      sb.push_back(x);
   endtask

   task automatic check_out();
      exp_t       x;
      logic [5:0] obs;
      obs = {estado, activo_comida, activo_medicina, modo_test};
      n_checks++;
      if (sb.size() == 0) begin
         n_errors++;
         $display("FAIL scoreboard: observed=%b expected=<empty queue>", obs);
      end else begin
         x = sb.pop_front();
         assert (obs === x.val) else begin
            n_errors++;
            $error("FAIL %s: observed est=%0d com=%b med=%b tst=%b expected est=%0d com=%b med=%b tst=%b",
                   x.tag, obs[5:3], obs[2], obs[1], obs[0], x.val[5:3], x.val[2], x.val[1], x.val[0]);
         end
      end
   endtask

   task automatic step(input string tag, input int est, input int com, input int med, input int tst);
      expect_out(tag, est, com, med, tst);
      tick();
      check_out();
   endtask

   initial begin
      reset = 1'b1;
      test  = 1'b0;
      set_lv(3, 3, 3, 3);
      repeat (3) @(posedge clk);
      #1;
      expect_out("reset", 0, 1, 0, 0);
      check_out();
      reset = 1'b0;
      step("idle", 0, 1, 0, 0);

      // Priority and DORMIDO behaviour
      set_lv(3, 1, 3, 1); step("enfermo_gana", 4, 1, 1, 0);
      set_lv(3, 1, 3, 3); step("hambre", 1, 1, 0, 0);
      set_lv(3, 3, 0, 3); step("dormido", 5, 0, 0, 0);
      set_lv(3, 3, 1, 3); step("dormido_d1", 5, 0, 0, 0);
      set_lv(1, 1, 1, 3); step("dormido_ignora", 5, 0, 0, 0);
      set_lv(3, 3, 1, 1); step("enfermo_sobre_dormido", 4, 1, 1, 0);
      set_lv(3, 3, 1, 3); step("cansado", 2, 1, 0, 0);
      set_lv(3, 3, 0, 3); step("dormido2", 5, 0, 0, 0);
      set_lv(1, 3, 2, 3); step("despierta_triste", 3, 1, 0, 0);
      set_lv(3, 3, 2, 3); step("neutral", 0, 1, 0, 0);

      // Death counter: 29 cycles is not enough, and release clears the count
      set_lv(3, 0, 3, 3); repeat (28) tick(); step("casi_muerto", 1, 1, 0, 0);
      set_lv(3, 2, 3, 3); step("recupera", 0, 1, 0, 0);
      set_lv(3, 3, 3, 0); repeat (28) tick(); step("contador_limpio", 4, 1, 1, 0);
      set_lv(3, 3, 3, 3); step("sana", 0, 1, 0, 0);

      // Test mode walk with levels ignored
      test = 1'b1; step("test_entra", 0, 0, 0, 1); test = 1'b0;
      set_lv(0, 0, 0, 0);
      for (int k = 0; k < 7; k++) begin
         repeat (8) tick();
         step("test_mantiene", k, 0, 0, 1);
         step("test_avanza", (k + 1) % 7, 0, 0, 1);
      end
      set_lv(3, 0, 3, 3);
      test = 1'b1; step("test_sale", 1, 1, 0, 0); test = 1'b0;

      // Death counter restarts from zero after test; terminal count beats a test pulse
      repeat (28) tick();
      step("muerte_retenida", 1, 1, 0, 0);
      test = 1'b1; step("muerte_gana_test", 6, 0, 0, 0); test = 1'b0;
      test = 1'b1; step("muerto_ignora_test", 6, 0, 0, 0); test = 1'b0;
      set_lv(3, 3, 3, 3); step("muerto_pegajoso", 6, 0, 0, 0);

      // Asynchronous reset out of MUERTO
      #2 reset = 1'b1;
      #1 expect_out("reset_muerto", 0, 1, 0, 0);
      check_out();
      reset = 1'b0;
      step("tras_reset", 0, 1, 0, 0);

      // Reset mid-test
      test = 1'b1; step("test_entra2", 0, 0, 0, 1); test = 1'b0;
      repeat (14) tick();
      step("test_estado1", 1, 0, 0, 1);
      #2 reset = 1'b1;
      #1 expect_out("reset_en_test", 0, 1, 0, 0);
      check_out();
      reset = 1'b0;
      step("tras_reset_test", 0, 1, 0, 0);

      // Fresh test entry after reset starts its timer from zero
      test = 1'b1; step("test_entra3", 0, 0, 0, 1); test = 1'b0;
      repeat (8) tick();
      step("test3_mantiene", 0, 0, 0, 1);
      step("test3_avanza", 1, 0, 0, 1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
